// File: rtl/puf_race_ctrl.sv
// puf_race_ctrl: race-PUF response sequencer, optional bit timeout via PUF_RACE_TIMEOUT_EN
module puf_race_ctrl #(
    parameter int RESP_BITS  = 8,
    parameter int TMO_CYCLES = 64,
    parameter int TMO_BITS   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_valid_a,
    input  logic                 i_valid_b,
    output logic                 o_cnt_en,
    output logic                 o_cnt_rst_n,
    output logic [RESP_BITS-1:0] o_resp,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic                 o_busy,
    output logic                 o_tie,
    output logic                 o_err
);
    localparam int IW = $clog2(RESP_BITS);
    localparam logic [IW-1:0] LAST = IW'(RESP_BITS - 1);
    typedef enum logic [1:0] {IDLE, CLR, RACE, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic hit, tmo_hit;
    assign hit = i_valid_a | i_valid_b;
    if (RESP_BITS < 2 || RESP_BITS > 32 || TMO_CYCLES < 2 || TMO_CYCLES >= 2**TMO_BITS) begin : g_bad
        $error("puf_race_ctrl: parameter out of range");
    end
`ifdef PUF_RACE_TIMEOUT_EN
    logic [TMO_BITS-1:0] tmo;
    assign tmo_hit = !hit && tmo == TMO_BITS'(TMO_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo   <= '0;
            o_err <= 1'b0;
        end else begin
            tmo <= (state == RACE) ? tmo + 1'b1 : '0;
            if (state == IDLE && i_start) o_err <= 1'b0;
            else if (state == RACE && tmo_hit) o_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign o_err   = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = i_start ? CLR : IDLE;
            CLR:  state_nx = RACE;
            RACE: state_nx = (hit && idx != LAST) ? CLR : (hit || tmo_hit) ? DONE : RACE;
            DONE: state_nx = i_resp_ready ? IDLE : DONE;
        endcase
    end
    // counter clear is registered so it stays low through reset and only rises from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            o_resp      <= '0;
            o_tie       <= 1'b0;
            o_cnt_rst_n <= 1'b0;
        end else begin
            state       <= state_nx;
            o_cnt_rst_n <= state_nx != CLR;
            if (state == IDLE && i_start) begin
                idx    <= '0;
                o_resp <= '0;
                o_tie  <= 1'b0;
            end
            if (state == RACE && hit) begin
                o_resp[idx] <= i_valid_a & ~i_valid_b;
                o_tie       <= o_tie | (i_valid_a & i_valid_b);
                if (idx != LAST) idx <= idx + 1'b1;
            end
        end
    end
    assign o_cnt_en     = state == RACE;
    assign o_busy       = state != IDLE;
    assign o_resp_valid = state == DONE;
endmodule

// File: tb/tb_puf_race_ctrl.sv
// tb_puf_race_ctrl: scenario-driven expectations for puf_race_ctrl, checked every cycle
module tb_puf_race_ctrl;
    localparam int TMO = 64;
    logic clk = 1'b0, rst, i_start, i_valid_a, i_valid_b, i_resp_ready;
    logic o_cnt_en, o_cnt_rst_n, o_resp_valid, o_busy, o_tie, o_err;
    logic [7:0] o_resp;
    logic e_busy, e_en, e_rstn, e_valid;
    logic [7:0] m_resp;
    logic m_tie, m_err;
    int checks = 0, errors = 0, clr_cnt = 0;

    puf_race_ctrl #(.RESP_BITS(8), .TMO_CYCLES(TMO), .TMO_BITS(7)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_valid_a(i_valid_a), .i_valid_b(i_valid_b),
        .o_cnt_en(o_cnt_en), .o_cnt_rst_n(o_cnt_rst_n), .o_resp(o_resp), .o_resp_valid(o_resp_valid),
        .i_resp_ready(i_resp_ready), .o_busy(o_busy), .o_tie(o_tie), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("busy", 32'(o_busy), 32'(e_busy));
        check("cnt_en", 32'(o_cnt_en), 32'(e_en));
        check("cnt_rst_n", 32'(o_cnt_rst_n), 32'(e_rstn));
        check("resp_valid", 32'(o_resp_valid), 32'(e_valid));
        check("resp", 32'(o_resp), 32'(m_resp));
        check("tie", 32'(o_tie), 32'(m_tie));
        check("err", 32'(o_err), 32'(m_err));
        if (!o_cnt_rst_n && o_busy) clr_cnt++;
    end

    // drive one cycle of inputs and state what the outputs must be after the next edge
    task automatic tick(input logic r, input logic s, input logic a, input logic b, input logic rd,
                        input logic eb, input logic ee, input logic er, input logic ev);
        rst = r; i_start = s; i_valid_a = a; i_valid_b = b; i_resp_ready = rd;
        e_busy = eb; e_en = ee; e_rstn = er; e_valid = ev;
        @(negedge clk);
    endtask

    // kinds: 2 bits per response bit, 0 A wins, 1 B wins, 2 tie, 3 no valid (timeout)
    task automatic run_word(input logic [15:0] kinds, input int dly, input int abort_at);
        logic [1:0] k;
        clr_cnt = 0;
        m_resp = '0; m_tie = 1'b0; m_err = 1'b0;
        tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            k = kinds[2*i +: 2];
            tick(0, 1, 1, 1, 0, 1, 1, 1, 0);
            if (i == abort_at) begin
                m_resp = '0; m_tie = 1'b0; m_err = 1'b0;
                tick(1, 0, 1, 0, 0, 0, 0, 0, 0);
                tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
                return;
            end
            if (k == 2'd3) begin
                for (int c = 1; c < TMO; c++) tick(0, 1, 0, 0, 0, 1, 1, 1, 0);
                m_err = 1'b1;
                tick(0, 0, 0, 0, 0, 1, 0, 1, 1);
                return;
            end
            for (int c = 1; c < dly; c++) tick(0, 1, 0, 0, 0, 1, 1, 1, 0);
            if (k == 2'd0) m_resp[i] = 1'b1;
            if (k == 2'd2) m_tie = 1'b1;
            if (i == 7) tick(0, 0, k != 2'd1, k != 2'd0, 0, 1, 0, 1, 1);
            else        tick(0, 0, k != 2'd1, k != 2'd0, 0, 1, 0, 0, 0);
        end
    endtask

    task automatic finish_word(input int hold);
        for (int h = 0; h < hold; h++) tick(0, h == hold / 2, 1, 0, 0, 1, 0, 1, 1);
        tick(0, 1, 0, 1, 1, 0, 0, 1, 0);
        tick(0, 0, 1, 1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        m_resp = '0; m_tie = 1'b0; m_err = 1'b0;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0, 1, 0);

        run_word(16'h4444, 3, -1);
        finish_word(10);
        check("word1_resp", 32'(o_resp), 32'h55);
        check("word1_tie", 32'(o_tie), 32'h0);
        check("word1_clr_pulses", 32'(clr_cnt), 32'd8);

        run_word(16'h0080, 1, -1);
        finish_word(2);
        check("word2_resp", 32'(o_resp), 32'hF7);
        check("word2_tie", 32'(o_tie), 32'h1);

        run_word(16'h1111, 5, -1);
        finish_word(0);
        check("word3_resp", 32'(o_resp), 32'hAA);

        run_word(16'h4444, 2, 4);
        check("abort_resp", 32'(o_resp), 32'h00);
        check("abort_valid", 32'(o_resp_valid), 32'h0);
        run_word(16'h0000, 1, -1);
        finish_word(1);
        check("fresh_resp", 32'(o_resp), 32'hFF);
        check("fresh_clr_pulses", 32'(clr_cnt), 32'd8);

`ifdef PUF_RACE_TIMEOUT_EN
        run_word(16'h0030, 2, -1);
        finish_word(3);
        check("tmo_resp", 32'(o_resp), 32'h03);
        check("tmo_err", 32'(o_err), 32'h1);
        run_word(16'h0000, 1, -1);
        finish_word(1);
        check("after_tmo_err", 32'(o_err), 32'h0);
`else
        run_word(16'h0000, 80, -1);
        finish_word(1);
        check("slow_resp", 32'(o_resp), 32'hFF);
        check("slow_err", 32'(o_err), 32'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/puf_race_ctrl.md
PUF_RACE_CTRL -- requirements
Module: puf_race_ctrl

Interface
REQ-001 SHALL have parameter RESP_BITS, default 8, number of race bits per response word (2..32).
REQ-002 SHALL have parameter TMO_CYCLES, default 64, maximum RACE-state cycles per bit before timeout (2..2^TMO_BITS-1).
REQ-003 SHALL have parameter TMO_BITS, default 7, width of the timeout counter.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_start, input, 1, request one response word; sampled only in IDLE.
REQ-007 SHALL have port i_valid_a, input, 1, valid pulse from counter A.
REQ-008 SHALL have port i_valid_b, input, 1, valid pulse from counter B.
REQ-009 SHALL have port o_cnt_en, output, 1, count enable to both counters.
REQ-010 SHALL have port o_cnt_rst_n, output, 1, active-low clear to both counters.
REQ-011 SHALL have port o_resp, output, RESP_BITS, response word.
REQ-012 SHALL have port o_resp_valid, output, 1, o_resp holds a valid word.
REQ-013 SHALL have port i_resp_ready, input, 1, consumer accepts o_resp.
REQ-014 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port o_tie, output, 1, sticky flag: at least one race in this word was a tie.
REQ-016 SHALL have port o_err, output, 1, sticky flag: word aborted by timeout.

Function
REQ-017 SHALL implement registered FSM with states IDLE, CLR, RACE, DONE; all outputs registered or decoded from state only.
REQ-018 In IDLE, i_start=1 SHALL clear bit index, o_resp, o_tie and o_err, then move to CLR; otherwise remain in IDLE.
REQ-019 SHALL ignore i_start in every state except IDLE.
REQ-020 CLR SHALL last exactly 1 cycle with o_cnt_rst_n=0 and o_cnt_en=0, clear the timeout counter, then go to RACE.
REQ-021 RACE SHALL drive o_cnt_en=1 and o_cnt_rst_n=1 and increment the timeout counter every cycle.
REQ-022 In RACE, i_valid_a=1 with i_valid_b=0 SHALL write 1 into o_resp[index]; i_valid_b=1 with i_valid_a=0 SHALL write 0.
REQ-023 In RACE, simultaneous i_valid_a=i_valid_b=1 SHALL write 0 into o_resp[index] and set o_tie.
REQ-024 After a bit is written, SHALL go to DONE if index==RESP_BITS-1, else increment index and go to CLR.
REQ-025 o_cnt_en SHALL be 0 in the cycle after a bit is resolved (no extra counting past the winning edge).
REQ-026 i_valid_a/i_valid_b SHALL be ignored outside RACE.
REQ-027 SHALL assert o_resp_valid only in DONE, with o_resp stable until handshake.
REQ-028 In DONE, i_resp_ready=1 SHALL complete the transfer and return to IDLE next cycle; o_resp, o_tie, o_err hold their values until the next accepted i_start.
REQ-029 An i_start in the cycle DONE returns to IDLE SHALL NOT be accepted; earliest acceptance is the first IDLE cycle.
REQ-030 Per bit, latency from entering CLR to bit write SHALL be 1 + (RACE cycles until first valid).

Reset
REQ-031 rst=1 SHALL force, on the next clock edge, state IDLE, index 0, timeout counter 0, o_resp 0, o_resp_valid 0, o_tie 0, o_err 0, o_busy 0, o_cnt_en 0, o_cnt_rst_n 0.
REQ-032 rst asserted mid-word SHALL abandon the word with no o_resp_valid pulse; o_cnt_rst_n SHALL return to 1 only from IDLE onward after rst deasserts.

Configuration
REQ-033 Macro PUF_RACE_TIMEOUT_EN defined: if the timeout counter reaches TMO_CYCLES-1 in RACE with no valid, SHALL set o_err, leave remaining bits 0, and go to DONE.
REQ-034 PUF_RACE_TIMEOUT_EN undefined: no timeout counter is built, RACE waits indefinitely, o_err SHALL be tied 0.

Verification
REQ-035 RESP_BITS=8; pulse i_start; in each RACE assert i_valid_a on the 3rd cycle for bits 0,2,4,6 and i_valid_b for others -> o_resp=8'h55, o_tie=0, o_err=0, o_resp_valid high until i_resp_ready.
REQ-036 Bit 3 with both valids in same cycle, others A-wins -> o_resp=8'hF7, o_tie=1.
REQ-037 PUF_RACE_TIMEOUT_EN, TMO_CYCLES=64; bits 0-1 A-wins, no valid for bit 2 -> o_err=1, o_resp=8'h03, DONE after 64 RACE cycles.
REQ-038 Hold i_resp_ready=0 for 10 cycles in DONE, pulse i_start -> o_resp unchanged, start ignored, o_busy=1; release ready -> IDLE.
REQ-039 Assert rst during RACE of bit 4 -> next cycle all outputs at reset values, no o_resp_valid; new i_start yields a fresh full word.
REQ-040 Check o_cnt_rst_n low exactly 1 cycle before each RACE and o_cnt_en high only in RACE cycles (8 CLR pulses per 8-bit word).
